// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial adder controller: adds two N-bit operands one bit per clock, LSB
// first, through a single one-bit full-adder cell. Owns the operand shift
// registers, the carry flip-flop, the bit counter and the start/done handshake.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst    synchronous, active-high reset (priority over i_start)
//   i_start  request; sampled only in IDLE or DONE
//   i_a/i_b  operands, captured on the accepting edge
//   i_cin    carry in, captured on the accepting edge
//   o_busy   high while an addition is in progress
//   o_done   one-cycle pulse: o_s/o_cout just updated
//   o_s      registered sum of the last completed addition
//   o_cout   registered carry out of the last completed addition
module serial_add_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_s,
  output logic         o_cout
);

  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_psum;
  logic [N-1:0]    r_s;
  logic            r_carry;
  logic            r_cout;
  logic [CntW-1:0] r_cnt;

  logic            w_sum;
  logic            w_carry;
  logic            w_accept;
  logic            w_last;
  logic [N-1:0]    w_psum_nxt;

  // One-bit full-adder cell fed from the operand LSBs and the carry flop.
  assign w_sum   = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));

  // Counter holds the index of the bit being processed; the edge that
  // processes bit N-1 is the completing edge.
  assign w_last = (r_cnt == CntW'(N - 1));

  // New sum bit enters at the MSB; after N shifts the register holds the sum.
  always_comb begin
    w_psum_nxt        = r_psum >> 1;
    w_psum_nxt[N-1]   = w_sum;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        if (w_last) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        // Back-to-back acceptance straight from the done cycle.
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = StRun;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a     <= i_a;
        r_b     <= i_b;
        r_carry <= i_cin;
        r_cnt   <= '0;
      end else if (r_state == StRun) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_carry <= w_carry;
        r_psum  <= w_psum_nxt;
        r_cnt   <= r_cnt + CntW'(1);
        if (w_last) begin
          r_s    <= w_psum_nxt;
          r_cout <= w_carry;
        end
      end
    end
  end

  // All outputs come straight from flops: no input-to-output combinational path.
  assign o_busy = (r_state == StRun);
  assign o_done = (r_state == StDone);
  assign o_s    = r_s;
  assign o_cout = r_cout;

endmodule
